// File: rtl/systolic_pkg.sv
// Shared types and constants for systolic_feeder_2 and its pair buffer.
package systolic_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_READY = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  localparam logic [63:0] ZERO_WORD = 64'd0;

endpackage

// File: rtl/pair_buf.sv
// DEPTH x W register file: one write port and one registered read port.
// Storage is deliberately not reset.
module pair_buf #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/systolic_feeder_2.sv
// Frame collector/replayer feeding systolic_2: loads up to DEPTH (x1,x2) pairs, issues them on go.
// Optional macro FEEDER_REPLAY_EN: keep the frame after issue and allow re-issue / explicit flush.
module systolic_feeder_2
  import systolic_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_x1,
  input  logic [DW-1:0] in_x2,
  input  logic          in_last,
  input  logic          go,
  output logic          busy,
  output logic          start,
  output logic [DW-1:0] x01,
  output logic [DW-1:0] x02,
  output logic          done
);

  localparam int unsigned CW = AW + 1;

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_idx;
  logic [AW-1:0]   r_rd_ptr;
  logic            w_hs;
  logic            w_frame_end;
  logic [2*DW-1:0] w_rdata;

  assign w_hs        = in_valid & in_ready & (r_state == ST_LOAD);
  assign w_frame_end = in_last | ((r_count + CW'(1)) == CW'(DEPTH));

  pair_buf #(
    .W     (2 * DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_hs),
    .i_waddr (r_count[AW-1:0]),
    .i_wdata ({in_x2, in_x1}),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // rd_ptr runs one ahead of the output index so the registered read lands in time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_LOAD;
      r_count  <= '0;
      r_idx    <= '0;
      r_rd_ptr <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      start    <= 1'b0;
      done     <= 1'b0;
      x01      <= DW'(ZERO_WORD);
      x02      <= DW'(ZERO_WORD);
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      case (r_state)
        ST_LOAD: begin
          in_ready <= 1'b1;
          if (w_hs) begin
            r_count <= r_count + CW'(1);
            if (w_frame_end) begin
              r_state  <= ST_READY;
              in_ready <= 1'b0;
            end
          end
        end
        ST_READY: begin
          in_ready <= 1'b0;
          if (go) begin
            r_state  <= ST_ISSUE;
            r_idx    <= '0;
            r_rd_ptr <= AW'(1);
          end
`ifdef FEEDER_REPLAY_EN
          else if (in_valid && in_last) begin
            r_count  <= '0;
            r_state  <= ST_LOAD;
            in_ready <= 1'b1;
          end
`endif
        end
        ST_ISSUE: begin
          if (r_idx < r_count) begin
            start    <= (r_idx == '0);
            busy     <= 1'b1;
            x01      <= w_rdata[DW-1:0];
            x02      <= w_rdata[2*DW-1:DW];
            r_idx    <= r_idx + CW'(1);
            r_rd_ptr <= r_rd_ptr + AW'(1);
          end else begin
            busy     <= 1'b0;
            done     <= 1'b1;
            x01      <= DW'(ZERO_WORD);
            x02      <= DW'(ZERO_WORD);
            r_rd_ptr <= '0;
`ifdef FEEDER_REPLAY_EN
            r_state  <= ST_READY;
`else
            r_state  <= ST_LOAD;
            r_count  <= '0;
            in_ready <= 1'b1;
`endif
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

endmodule
